// File: rtl/game_ctrl_pkg.sv
// Shared types and widths for the rhythm-game play controller.
package game_ctrl_pkg;

    localparam int SCORE_W = 11;
    localparam int TIME_W  = 10;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COUNTDOWN = 3'd1,
        ST_PLAYING   = 3'd2,
        ST_PAUSED    = 3'd3,
        ST_RESULT    = 3'd4
    } state_t;

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for an already debounced, synchronised button.
module btn_edge (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_btn,
    output logic o_rise
);

    logic r_prev;

    // prev resets high so a button held through reset yields no edge
    always_ff @(posedge i_clock) begin
        if (i_reset) r_prev <= 1'b1;
        else         r_prev <= i_btn;
    end

    assign o_rise = i_btn & ~r_prev;

endmodule

// File: rtl/game_sequencer.sv
// Round sequencer: idle, 3-2-1 countdown, play, pause, result display.
module game_sequencer
    import game_ctrl_pkg::*;
#(
    parameter int                COUNT_TICKS = 10000000,
    parameter logic [TIME_W-1:0] SONG_END    = 10'd960,
    parameter int                RESULT_HOLD = 10
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start_btn,
    input  logic               pause_btn,
    input  logic [TIME_W-1:0]  counter10h,
    input  logic [SCORE_W-1:0] score,
    output logic               game_run,
    output logic               game_clear,
    output logic [2:0]         state,
    output logic [1:0]         countdown,
    output logic [SCORE_W-1:0] final_score,
    output logic [SCORE_W-1:0] high_score,
    output logic               new_record
);

    localparam int PW = $clog2(COUNT_TICKS + 1);
    localparam int HW = $clog2(RESULT_HOLD + 1);

    logic w_start_rise;
    logic w_pause_rise;
    logic w_wrap;

    state_t             r_state,  w_state_nx;
    logic [PW-1:0]      r_presc,  w_presc_nx;
    logic [HW-1:0]      r_hold,   w_hold_nx;
    logic [1:0]         r_cd,     w_cd_nx;
    logic               r_run,    w_run_nx;
    logic               r_clear,  w_clear_nx;
    logic [SCORE_W-1:0] r_final,  w_final_nx;
    logic [SCORE_W-1:0] r_high,   w_high_nx;
    logic               r_rec,    w_rec_nx;

    btn_edge u_start_edge (
        .i_clock (clock),
        .i_reset (reset),
        .i_btn   (start_btn),
        .o_rise  (w_start_rise)
    );

    btn_edge u_pause_edge (
        .i_clock (clock),
        .i_reset (reset),
        .i_btn   (pause_btn),
        .o_rise  (w_pause_rise)
    );

    assign w_wrap = (r_presc == PW'(COUNT_TICKS - 1));

    always_comb begin
        w_state_nx = r_state;
        w_presc_nx = r_presc;
        w_hold_nx  = r_hold;
        w_cd_nx    = r_cd;
        w_clear_nx = 1'b0;
        w_final_nx = r_final;
        w_high_nx  = r_high;
        w_rec_nx   = r_rec;

        case (r_state)
            ST_IDLE: begin
                if (w_start_rise) begin
                    w_state_nx = ST_COUNTDOWN;
                    w_cd_nx    = 2'd3;
                    w_clear_nx = 1'b1;
                end
            end
            ST_COUNTDOWN: begin
                w_presc_nx = w_wrap ? '0 : r_presc + 1'b1;
                if (w_wrap) begin
                    if (r_cd > 2'd1) begin
                        w_cd_nx = r_cd - 2'd1;
                    end else begin
                        w_state_nx = ST_PLAYING;
                        w_cd_nx    = 2'd0;
                    end
                end
            end
            ST_PLAYING: begin
                if (counter10h >= SONG_END) begin
                    w_state_nx = ST_RESULT;
                    w_final_nx = score;
                    w_rec_nx   = (score > r_high);
                    if (score > r_high) w_high_nx = score;
                end else if (w_pause_rise) begin
                    w_state_nx = ST_PAUSED;
                end
            end
            ST_PAUSED: begin
                if (w_start_rise) begin
                    w_state_nx = ST_IDLE;
                    w_clear_nx = 1'b1;
                end else if (w_pause_rise) begin
                    w_state_nx = ST_PLAYING;
                end
            end
            ST_RESULT: begin
                // a restart request beats the display timeout
                if (w_start_rise) begin
                    w_state_nx = ST_COUNTDOWN;
                    w_cd_nx    = 2'd3;
                    w_clear_nx = 1'b1;
                end else begin
                    w_presc_nx = w_wrap ? '0 : r_presc + 1'b1;
                    if (w_wrap) begin
                        if (r_hold == HW'(RESULT_HOLD - 1)) w_state_nx = ST_IDLE;
                        else                               w_hold_nx  = r_hold + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_cd_nx    = 2'd0;
            end
        endcase

        if (w_state_nx != r_state) begin
            w_presc_nx = '0;
            w_hold_nx  = '0;
        end
        if (w_state_nx != ST_RESULT) w_rec_nx = 1'b0;
        w_run_nx = (w_state_nx == ST_PLAYING);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_presc <= '0;
            r_hold  <= '0;
            r_cd    <= 2'd0;
            r_run   <= 1'b0;
            r_clear <= 1'b1;
            r_final <= '0;
            r_high  <= '0;
            r_rec   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_presc <= w_presc_nx;
            r_hold  <= w_hold_nx;
            r_cd    <= w_cd_nx;
            r_run   <= w_run_nx;
            r_clear <= w_clear_nx;
            r_final <= w_final_nx;
            r_high  <= w_high_nx;
            r_rec   <= w_rec_nx;
        end
    end

    assign state       = r_state;
    assign countdown   = r_cd;
    assign game_run    = r_run;
    assign game_clear  = r_clear;
    assign final_score = r_final;
    assign high_score  = r_high;
    assign new_record  = r_rec;

endmodule
